// File: rtl/icache_pkg.sv
// Shared types and address-field sizing for the direct-mapped instruction cache.
// Field widths are derived from the LINES/WORDS parameters through the helpers below.
package icache_pkg;

    typedef enum logic [1:0] {LOOKUP, REQ, FILL, RESP} state_e;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int OFF_W  = 2;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int tag_w(input int lines, input int words);
        return ADDR_W - OFF_W - idx_w(lines) - idx_w(words);
    endfunction

    function automatic int beat_w(input int words);
        return idx_w(words);
    endfunction

endpackage

// File: rtl/icache_array.sv
// Tag/valid/data storage: one synchronous write port, one combinational read port.
// Valid bits reset and flash-clear; a valid-setting write wins over a same-cycle clear.
module icache_array
    import icache_pkg::*;
#(
    parameter int LINES = 16,
    parameter int WORDS = 4
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          inv_i,
    input  logic                          we_i,
    input  logic                          set_valid_i,
    input  logic [idx_w(LINES)-1:0]       wr_line_i,
    input  logic [idx_w(WORDS)-1:0]       wr_word_i,
    input  logic [DATA_W-1:0]             wr_data_i,
    input  logic [tag_w(LINES,WORDS)-1:0] wr_tag_i,
    input  logic [idx_w(LINES)-1:0]       rd_line_i,
    input  logic [idx_w(WORDS)-1:0]       rd_word_i,
    output logic                          rd_valid_o,
    output logic [tag_w(LINES,WORDS)-1:0] rd_tag_o,
    output logic [DATA_W-1:0]             rd_data_o
);

    localparam int TAG_W = tag_w(LINES, WORDS);

    logic [LINES-1:0]  valid_q;
    logic [TAG_W-1:0]  tag_q  [LINES];
    logic [DATA_W-1:0] data_q [LINES*WORDS];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= '0;
        end else begin
            if (inv_i)
                valid_q <= '0;
            if (we_i && set_valid_i)
                valid_q[wr_line_i] <= 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (we_i)
            data_q[{wr_line_i, wr_word_i}] <= wr_data_i;
        if (we_i && set_valid_i)
            tag_q[wr_line_i] <= wr_tag_i;
    end

    assign rd_valid_o = valid_q[rd_line_i];
    assign rd_tag_o   = tag_q[rd_line_i];
    assign rd_data_o  = data_q[{rd_line_i, rd_word_i}];

endmodule

// File: rtl/icache_dm.sv
// Direct-mapped instruction cache with single-request line refill.
// Define ICACHE_STATS_EN to add hit_count / miss_count outputs.
module icache_dm
    import icache_pkg::*;
#(
    parameter int LINES = 16,
    parameter int WORDS = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] icache_addr,
    input  logic        icache_re,
    output logic [31:0] icache_dout,
    output logic        stall_i,
    input  logic        invalidate,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [31:0] mem_req_addr,
    input  logic        mem_resp_valid,
    input  logic [31:0] mem_resp_data
`ifdef ICACHE_STATS_EN
    ,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
`endif
);

    localparam int LIDX_W = idx_w(LINES);
    localparam int WIDX_W = idx_w(WORDS);
    localparam int TAG_W  = tag_w(LINES, WORDS);
    localparam int BEAT_W = beat_w(WORDS);
    localparam int LSB_W  = OFF_W + WIDX_W;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(WORDS - 1);

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   req_addr_q, req_addr_d;
    logic                pend_q, pend_d;
    logic [DATA_W-1:0]   dout_q, dout_d;
    logic [ADDR_W-1:0]   maddr_q, maddr_d;
    logic [BEAT_W-1:0]   beat_q, beat_d;

    logic [WIDX_W-1:0]   req_word;
    logic [LIDX_W-1:0]   req_line;
    logic [TAG_W-1:0]    req_tag;
    logic                rd_valid;
    logic [TAG_W-1:0]    rd_tag;
    logic [DATA_W-1:0]   rd_data;
    logic                hit, we, set_valid, lookup_hit, lookup_miss;

    assign req_word = req_addr_q[OFF_W +: WIDX_W];
    assign req_line = req_addr_q[LSB_W +: LIDX_W];
    assign req_tag  = req_addr_q[ADDR_W-1 -: TAG_W];
    assign hit      = pend_q && rd_valid && (rd_tag == req_tag);

    icache_array #(.LINES(LINES), .WORDS(WORDS)) u_array (
        .clk_i       (clk),
        .rst_ni      (reset),
        .inv_i       (invalidate),
        .we_i        (we),
        .set_valid_i (set_valid),
        .wr_line_i   (req_line),
        .wr_word_i   (beat_q),
        .wr_data_i   (mem_resp_data),
        .wr_tag_i    (req_tag),
        .rd_line_i   (req_line),
        .rd_word_i   (req_word),
        .rd_valid_o  (rd_valid),
        .rd_tag_o    (rd_tag),
        .rd_data_o   (rd_data)
    );

    always_comb begin
        state_d       = state_q;
        req_addr_d    = req_addr_q;
        pend_d        = pend_q;
        dout_d        = dout_q;
        maddr_d       = maddr_q;
        beat_d        = beat_q;
        icache_dout   = dout_q;
        stall_i       = 1'b0;
        mem_req_valid = 1'b0;
        we            = 1'b0;
        set_valid     = 1'b0;
        lookup_hit    = 1'b0;
        lookup_miss   = 1'b0;
        case (state_q)
            LOOKUP: if (pend_q) begin
                if (hit) begin
                    icache_dout = rd_data;
                    dout_d      = rd_data;
                    pend_d      = 1'b0;
                    lookup_hit  = 1'b1;
                end else begin
                    stall_i     = 1'b1;
                    lookup_miss = 1'b1;
                    maddr_d     = {req_addr_q[ADDR_W-1:LSB_W], {LSB_W{1'b0}}};
                    beat_d      = '0;
                    state_d     = REQ;
                end
            end
            REQ: begin
                stall_i       = 1'b1;
                mem_req_valid = 1'b1;
                if (mem_req_ready)
                    state_d = FILL;
            end
            FILL: begin
                stall_i = 1'b1;
                if (mem_resp_valid) begin
                    we     = 1'b1;
                    beat_d = beat_q + 1'b1;
                    if (beat_q == LAST_BEAT) begin
                        set_valid = 1'b1;
                        state_d   = RESP;
                    end
                end
            end
            RESP: begin
                icache_dout = rd_data;
                dout_d      = rd_data;
                pend_d      = 1'b0;
                state_d     = LOOKUP;
            end
            default: state_d = LOOKUP;
        endcase
        // A new fetch may be accepted in the same cycle an older one completes.
        if (icache_re && !stall_i) begin
            req_addr_d = icache_addr;
            pend_d     = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= LOOKUP;
            req_addr_q <= '0;
            pend_q     <= 1'b0;
            dout_q     <= '0;
            maddr_q    <= '0;
            beat_q     <= '0;
        end else begin
            state_q    <= state_d;
            req_addr_q <= req_addr_d;
            pend_q     <= pend_d;
            dout_q     <= dout_d;
            maddr_q    <= maddr_d;
            beat_q     <= beat_d;
        end
    end

    assign mem_req_addr = maddr_q;

`ifdef ICACHE_STATS_EN
    logic [31:0] hit_cnt_q, miss_cnt_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            if (lookup_hit)
                hit_cnt_q <= hit_cnt_q + 32'd1;
            if (lookup_miss)
                miss_cnt_q <= miss_cnt_q + 32'd1;
        end
    end

    assign hit_count  = hit_cnt_q;
    assign miss_count = miss_cnt_q;
`else
    logic unused_stats;
    assign unused_stats = lookup_hit ^ lookup_miss;
`endif

endmodule

// File: tb/tb_icache_dm.sv
// Directed bench for icache_dm: table of fetches plus invalidate and reset-mid-fill sequences.
module tb_icache_dm;

    localparam int WORDS = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] icache_addr = '0;
    logic        icache_re = 1'b0;
    logic [31:0] icache_dout;
    logic        stall_i;
    logic        invalidate = 1'b0;
    logic        mem_req_valid;
    logic        mem_req_ready = 1'b0;
    logic [31:0] mem_req_addr;
    logic        mem_resp_valid = 1'b0;
    logic [31:0] mem_resp_data = '0;

    int checks = 0;
    int failures = 0;

    icache_dm #(.LINES(16), .WORDS(WORDS)) dut (
        .clk            (clk),
        .reset          (reset),
        .icache_addr    (icache_addr),
        .icache_re      (icache_re),
        .icache_dout    (icache_dout),
        .stall_i        (stall_i),
        .invalidate     (invalidate),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_req_addr   (mem_req_addr),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_data  (mem_resp_data)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [31:0] addr;
        logic [31:0] exp;
        bit          miss;
        int          delay;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Backing memory contents: word at byte address a is (a>>2)+0x90.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a >> 2) + 32'h90;
    endfunction

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic do_read(input logic [31:0] addr, input logic [31:0] exp,
                           input bit miss, input int delay, input int inv_beat);
        logic [31:0] line;
        line = addr & ~32'hF;
        cyc(); icache_addr = addr; icache_re = 1'b1;
        cyc(); icache_re = 1'b0; icache_addr = 32'hDEAD_BEE0;
        #4;
        if (!miss) begin
            chk($sformatf("hit_stall@%h", addr), {31'd0, stall_i}, 32'd0);
            chk($sformatf("hit_data@%h", addr), icache_dout, exp);
            chk($sformatf("hit_noreq@%h", addr), {31'd0, mem_req_valid}, 32'd0);
        end else begin
            chk($sformatf("miss_stall@%h", addr), {31'd0, stall_i}, 32'd1);
            for (int i = 0; i <= delay; i++) begin
                cyc(); mem_req_ready = (i == delay); #4;
                chk($sformatf("req_valid@%h", addr), {31'd0, mem_req_valid}, 32'd1);
                chk($sformatf("req_addr@%h", addr), mem_req_addr, line);
                chk($sformatf("req_stall@%h", addr), {31'd0, stall_i}, 32'd1);
            end
            for (int w = 0; w < WORDS; w++) begin
                cyc();
                mem_req_ready  = 1'b0;
                mem_resp_valid = 1'b1;
                mem_resp_data  = mem_word(line + 32'(4 * w));
                invalidate     = (w == inv_beat);
                #4;
                chk($sformatf("fill_stall@%h", addr), {31'd0, stall_i}, 32'd1);
            end
            cyc(); mem_resp_valid = 1'b0; invalidate = 1'b0; mem_resp_data = 32'hBAD0_0000; #4;
            chk($sformatf("resp_stall@%h", addr), {31'd0, stall_i}, 32'd0);
            chk($sformatf("resp_data@%h", addr), icache_dout, exp);
        end
        cyc(); #4;
        chk($sformatf("hold_data@%h", addr), icache_dout, exp);
        chk($sformatf("idle_stall@%h", addr), {31'd0, stall_i}, 32'd0);
    endtask

    initial begin
        vecs[0]  = '{32'h0000_0040, 32'h0000_00A0, 1'b1, 0};
        vecs[1]  = '{32'h0000_0044, 32'h0000_00A1, 1'b0, 0};
        vecs[2]  = '{32'h0000_004C, 32'h0000_00A3, 1'b0, 0};
        vecs[3]  = '{32'h0000_0042, 32'h0000_00A0, 1'b0, 0};
        vecs[4]  = '{32'h0000_0440, 32'h0000_01A0, 1'b1, 5};
        vecs[5]  = '{32'h0000_0040, 32'h0000_00A0, 1'b1, 0};
        vecs[6]  = '{32'h0000_0080, 32'h0000_00B0, 1'b1, 2};
        vecs[7]  = '{32'h0000_0088, 32'h0000_00B2, 1'b0, 0};
        vecs[8]  = '{32'h0000_003C, 32'h0000_009F, 1'b1, 0};
        vecs[9]  = '{32'hFFFF_FFF0, 32'h4000_008C, 1'b1, 1};
        vecs[10] = '{32'hFFFF_FFF4, 32'h4000_008D, 1'b0, 0};
        vecs[11] = '{32'h0000_0038, 32'h0000_009E, 1'b0, 0};

        cyc(); cyc(); #4;
        chk("rst_stall", {31'd0, stall_i}, 32'd0);
        chk("rst_req_valid", {31'd0, mem_req_valid}, 32'd0);
        chk("rst_req_addr", mem_req_addr, 32'd0);
        chk("rst_dout", icache_dout, 32'd0);
        cyc(); reset = 1'b1;
        cyc(); #4;
        chk("idle_dout", icache_dout, 32'd0);

        foreach (vecs[i])
            do_read(vecs[i].addr, vecs[i].exp, vecs[i].miss, vecs[i].delay, -1);

        // Invalidate during the refill of 0x40: that line survives, others are dropped.
        do_read(32'h0000_0440, 32'h0000_01A0, 1'b1, 0, -1);
        do_read(32'h0000_0040, 32'h0000_00A0, 1'b1, 0, 1);
        do_read(32'h0000_0040, 32'h0000_00A0, 1'b0, 0, -1);
        do_read(32'h0000_0080, 32'h0000_00B0, 1'b1, 0, -1);
        do_read(32'h0000_003C, 32'h0000_009F, 1'b1, 0, -1);

        // Invalidate coinciding with a hit: the hit returns, then the line is gone.
        cyc(); icache_addr = 32'h0000_0080; icache_re = 1'b1;
        cyc(); icache_re = 1'b0; invalidate = 1'b1; #4;
        chk("invhit_stall", {31'd0, stall_i}, 32'd0);
        chk("invhit_data", icache_dout, 32'h0000_00B0);
        cyc(); invalidate = 1'b0;
        do_read(32'h0000_0080, 32'h0000_00B0, 1'b1, 0, -1);

        // Reset after two fill beats; later stray beats must not matter.
        cyc(); icache_addr = 32'h0000_0440; icache_re = 1'b1;
        cyc(); icache_re = 1'b0; #4;
        chk("rm_miss_stall", {31'd0, stall_i}, 32'd1);
        cyc(); mem_req_ready = 1'b1;
        for (int w = 0; w < 2; w++) begin
            cyc(); mem_req_ready = 1'b0; mem_resp_valid = 1'b1;
            mem_resp_data = mem_word(32'h440 + 32'(4 * w));
        end
        cyc(); mem_resp_valid = 1'b0; reset = 1'b0; #4;
        chk("rm_stall", {31'd0, stall_i}, 32'd0);
        chk("rm_req_valid", {31'd0, mem_req_valid}, 32'd0);
        chk("rm_req_addr", mem_req_addr, 32'd0);
        chk("rm_dout", icache_dout, 32'd0);
        cyc(); reset = 1'b1;
        for (int w = 0; w < 2; w++) begin
            cyc(); mem_resp_valid = 1'b1; mem_resp_data = 32'h5555_0000 + 32'(w); #4;
            chk("stray_stall", {31'd0, stall_i}, 32'd0);
            chk("stray_req", {31'd0, mem_req_valid}, 32'd0);
        end
        cyc(); mem_resp_valid = 1'b0;
        do_read(32'h0000_0040, 32'h0000_00A0, 1'b1, 0, -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/icache_dm.md
ICACHE_DM -- requirements
Module: icache_dm

Interface
REQ-001 SHALL have parameter LINES, default 16, number of direct-mapped lines (power of 2, >=2).
REQ-002 SHALL have parameter WORDS, default 4, 32-bit words per line (power of 2, >=2).
REQ-003 SHALL have port clk  input  1  rising-edge clock.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset (asserted at 0).
REQ-005 SHALL have port icache_addr  input  32  fetch byte address from the pipeline.
REQ-006 SHALL have port icache_re  input  1  fetch request.
REQ-007 SHALL have port icache_dout  output  32  fetched instruction word.
REQ-008 SHALL have port stall_i  output  1  miss in progress; pipeline holds.
REQ-009 SHALL have port invalidate  input  1  single-cycle pulse; clears all valid bits.
REQ-010 SHALL have port mem_req_valid  output  1  line-fill request.
REQ-011 SHALL have port mem_req_ready  input  1  memory accepts the request.
REQ-012 SHALL have port mem_req_addr  output  32  line-aligned byte address.
REQ-013 SHALL have port mem_resp_valid  input  1  one fill beat present.
REQ-014 SHALL have port mem_resp_data  input  32  fill beat, ascending word order.

Function
REQ-015 SHALL capture icache_addr into an internal request register on every cycle where icache_re=1 and stall_i=0.
REQ-016 SHALL decompose the address as offset[1:0], word index log2(WORDS), line index log2(LINES), tag = remaining upper bits.
REQ-017 SHALL, on a hit (valid and tag match), drive icache_dout with the addressed word the cycle after capture, with stall_i=0 (1-cycle latency).
REQ-018 SHALL use the FSM states LOOKUP, REQ, FILL, RESP; the reset state is LOOKUP.
REQ-019 SHALL, in LOOKUP on a miss with a pending request, assert stall_i combinationally that cycle and transition to REQ.
REQ-020 SHALL, in REQ, hold mem_req_valid=1 with a stable mem_req_addr until mem_req_ready=1, then transition to FILL.
REQ-021 SHALL, in FILL, write each mem_resp_valid beat to word counter 0..WORDS-1; after the last beat, set the tag and valid bit and transition to RESP.
REQ-022 SHALL, in RESP, drive the requested word on icache_dout with stall_i=0 for one cycle, then return to LOOKUP.
REQ-023 SHALL keep stall_i=1 throughout REQ and FILL.
REQ-024 SHALL ignore icache_addr changes while stall_i=1; the captured address governs the refill.
REQ-025 SHALL ignore mem_resp_valid outside FILL.
REQ-026 SHALL, when invalidate coincides with a hit lookup, return that hit and then clear all valid bits.
REQ-027 SHALL, when invalidate occurs during REQ or FILL, clear all valid bits immediately; the in-flight line still completes and is marked valid.
REQ-028 SHALL hold icache_dout at its last value when there is no pending request; it SHALL never be X after reset.

Reset
REQ-029 SHALL, while reset=0: clear all valid bits, set state=LOOKUP, stall_i=0, mem_req_valid=0, mem_req_addr=0, icache_dout=0, beat counter=0, and clear the pending request flag.
REQ-030 SHALL, on reset mid-refill, abandon the fill; beats arriving after deassertion are discarded; data arrays need not be reset.

Configuration
REQ-031 SHALL, with ICACHE_STATS_EN defined, add outputs hit_count (32) and miss_count (32), incremented once per LOOKUP hit and once per miss respectively, zeroed on reset, wrapping modulo 2^32.
REQ-032 SHALL, without ICACHE_STATS_EN, omit those ports and counters entirely.

Structure
REQ-033 SHALL place the FSM state enum, address field-width constants, and the beat-counter width in a shared package, icache_pkg.
REQ-034 SHALL implement the tag/valid/data storage as one sub-module, icache_array: one write port and one combinational read port.

Verification
REQ-035 Cold miss: read 0x0000_0040 after reset -> stall_i=1; mem_req_addr=0x40; four beats 0xA0..0xA3; then icache_dout=0xA0 in RESP and stall_i=0.
REQ-036 Same-line hit: following read 0x44 -> icache_dout=0xA1 next cycle; stall_i stays 0; no mem_req_valid.
REQ-037 Conflict: with LINES=16, WORDS=4, read 0x440 (same index as 0x40) -> miss and refill; re-read 0x40 -> miss again.
REQ-038 Backpressure: mem_req_ready held 0 for 5 cycles -> mem_req_valid and mem_req_addr stable for all 5; stall_i=1.
REQ-039 Invalidate: invalidate during FILL of 0x40 -> 0x40 hits afterwards; any previously valid line (e.g. 0x80) misses.
REQ-040 Reset mid-fill: reset pulsed after beat 2 -> all outputs at reset values; stray beats ignored; next read of 0x40 misses.
